// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - read-owner encoding and default parameters for mem_arbiter
package mem_arb_pkg;

  // Which requester the RAM read data returning next cycle belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_e;

  localparam int RAM_AW_DEF     = 7;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between a CPU port and a DMA requester
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_rd_en/cpu_rd_addr          CPU read request, held until cpu_rd_vld
//   cpu_wr_en/cpu_wr_addr/byte     CPU single-cycle write, never stalled
//   cpu_rd_byte/cpu_rd_vld         CPU read return
//   dma_req/dma_we/addr/wdata      DMA request, held until dma_gnt
//   dma_gnt                        DMA acceptance pulse (same cycle as its RAM command)
//   dma_rdata/dma_rvld             DMA read return
//   mem_en/we/addr/wdata           RAM command, combinational from this cycle's decision
//   mem_rdata                      RAM read data, one cycle after a read command
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_AW     = RAM_AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_en,
  input  logic [15:0]       cpu_rd_addr,
  input  logic              cpu_wr_en,
  input  logic [15:0]       cpu_wr_addr,
  input  logic [7:0]        cpu_wr_byte,
  output logic [7:0]        cpu_rd_byte,
  output logic              cpu_rd_vld,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [15:0]       dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic [7:0]        dma_rdata,
  output logic              dma_rvld,
  output logic              mem_en,
  output logic              mem_we,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_CPU_WR = 2'd1,
    SRC_CPU_RD = 2'd2,
    SRC_DMA    = 2'd3
  } src_e;

  src_e          win;
  rd_owner_e     rd_owner;
  logic          cpu_busy;
  logic [SW-1:0] starve_cnt;

  // Address bits above the RAM width alias and are intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_rd_addr[15:RAM_AW], cpu_wr_addr[15:RAM_AW],
                              dma_addr[15:RAM_AW]};

  // Arbitration: CPU write, starved DMA, CPU read, DMA.
  // Nothing wins while in reset so the command outputs read as zero.
  always_comb begin
    win = SRC_NONE;
    if (!rst_n)
      win = SRC_NONE;
    else if (cpu_wr_en)
      win = SRC_CPU_WR;
    else if (dma_req && (starve_cnt == STARVE_LIM))
      win = SRC_DMA;
    else if (cpu_rd_en && !cpu_busy)
      win = SRC_CPU_RD;
    else if (dma_req)
      win = SRC_DMA;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dma_gnt   = 1'b0;
    case (win)
      SRC_CPU_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_wr_addr[RAM_AW-1:0];
        mem_wdata = cpu_wr_byte;
      end
      SRC_CPU_RD: begin
        mem_en   = 1'b1;
        mem_addr = cpu_rd_addr[RAM_AW-1:0];
      end
      SRC_DMA: begin
        mem_en    = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr[RAM_AW-1:0];
        mem_wdata = dma_we ? dma_wdata : 8'h00;
        dma_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner   <= OWN_NONE;
      cpu_busy   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (win)
        SRC_CPU_RD: rd_owner <= OWN_CPU;
        SRC_DMA:    rd_owner <= dma_we ? OWN_NONE : OWN_DMA;
        default:    rd_owner <= OWN_NONE;
      endcase

      // cpu_rd_en stays high through the return cycle; busy masks it there
      if (win == SRC_CPU_RD)
        cpu_busy <= 1'b1;
      else if (cpu_rd_vld)
        cpu_busy <= 1'b0;

      if (dma_gnt)
        starve_cnt <= '0;
      else if (dma_req && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Returned data is steered only to the owner and zero elsewhere
  assign cpu_rd_vld  = (rd_owner == OWN_CPU);
  assign dma_rvld    = (rd_owner == OWN_DMA);
  assign cpu_rd_byte = cpu_rd_vld ? mem_rdata : 8'h00;
  assign dma_rdata   = dma_rvld ? mem_rdata : 8'h00;

endmodule
